// File: rtl/tff_count_if.sv
// Start/done handshake and bank-observation bundle for the T flip-flop count controller.
interface tff_count_if #(
  parameter int N = 4
);
  logic         start;
  logic         mode;
  logic [N-1:0] limit;
  logic [N-1:0] t_vec;
  logic [N-1:0] q;
  logic         busy;
  logic         done;

  modport master (
    output start, mode, limit,
    input  t_vec, q, busy, done
  );

  modport slave (
    input  start, mode, limit,
    output t_vec, q, busy, done
  );
endinterface

// File: rtl/tff_count_ctrl.sv
// Programmable up/down counter built as a controller driving the toggle inputs of a T flip-flop bank.
// A start request presets the bank, steps it by one per clock to the end value, then pulses done.
module tff_count_ctrl #(
  parameter int N = 4
) (
  input  logic      clk,
  input  logic      reset,
  tff_count_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] q_q;
  logic [N-1:0] limit_q, limit_d;
  logic         mode_q, mode_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N-1:0] t_vec_s;
  logic [N-1:0] end_s;

  // Toggle vector: preset in LOAD, ripple-carry/borrow increment in RUN until the end value.
  always_comb begin : t_vec_comb
    logic run_v;
    run_v   = 1'b1;
    end_s   = mode_q ? '0 : limit_q;
    t_vec_s = '0;
    case (state_q)
      S_LOAD: t_vec_s = q_q ^ (mode_q ? limit_q : '0);
      S_RUN: begin
        if (q_q != end_s) begin
          for (int i = 0; i < N; i++) begin
            t_vec_s[i] = run_v;
            run_v      = run_v & (mode_q ? ~q_q[i] : q_q[i]);
          end
        end else begin
          t_vec_s = '0;
        end
      end
      default: t_vec_s = '0;
    endcase
  end

  // Next-state, request capture and registered status decode.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          limit_d = bus.limit;
          mode_d  = bus.mode;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (q_q == end_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Controller state plus the T flip-flop bank, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_q ^ t_vec_s;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.t_vec = t_vec_s;
  assign bus.q     = q_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl: cycle-indexed reference model checked every cycle, plus directed scenarios.
module tb_tff_count_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  tff_count_if #(.N(4)) bus ();

  tff_count_ctrl #(.N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an operation is described by the number of edges since start was accepted (cnt=1 is the
  // preset cycle, cnt=L+3 the completion cycle) and q follows directly from that count.
  bit m_act = 1'b0;
  bit m_md  = 1'b0;
  int m_cnt = 0;
  int m_L   = 0;
  int m_q   = 0;
  bit chk_en = 1'b0;

  function automatic int qval(input int c, input int lim, input bit md);
    if (!md) return (c - 2 < lim) ? c - 2 : lim;
    return (lim - (c - 2) > 0) ? lim - (c - 2) : 0;
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_act  = 1'b0;
      m_q    = 0;
      m_cnt  = 0;
      chk_en = 1'b1;
    end else if (!m_act) begin
      if (bus.start) begin
        m_act = 1'b1;
        m_cnt = 1;
        m_L   = int'(bus.limit);
        m_md  = bus.mode;
      end
    end else begin
      m_cnt++;
      if (m_cnt > m_L + 3) m_act = 1'b0;
      else m_q = qval(m_cnt, m_L, m_md);
    end
  end

  initial forever begin
    logic [3:0] exp_tv;
    @(negedge clk);
    if (chk_en) begin
      exp_tv = 4'd0;
      if (m_act && m_cnt <= m_L + 2) exp_tv = 4'(qval(m_cnt + 1, m_L, m_md)) ^ 4'(m_q);
      chk("model_q", int'(bus.q), m_q);
      chk("model_busy", int'(bus.busy), int'(m_act));
      chk("model_done", int'(bus.done), int'(m_act && m_cnt == m_L + 3));
      chk("model_t_vec", int'(bus.t_vec), int'(exp_tv));
    end
  end

  // One start pulse; measures busy length, done pulses, LOAD toggle vector and RUN toggle at q=3.
  task automatic run_op(input logic [3:0] lim, input logic md, input bit poke,
                        input int exp_busy, input int exp_q,
                        output logic [3:0] load_tv, output logic [3:0] tv3);
    int  nb;
    int  nd;
    bit  got3;
    nb = 0; nd = 0; got3 = 1'b0; tv3 = 4'd0; load_tv = 4'd0;
    @(negedge clk);
    bus.start = 1'b1; bus.limit = lim; bus.mode = md;
    @(negedge clk);
    bus.start = 1'b0;
    load_tv = bus.t_vec;
    for (int i = 0; i < 60; i++) begin
      if (!bus.busy) break;
      nb++;
      if (bus.done) nd++;
      if (i > 0 && bus.q == 4'd3 && !got3) begin
        got3 = 1'b1;
        tv3  = bus.t_vec;
      end
      @(negedge clk);
      if (poke && i == 2) begin
        bus.start = 1'b1; bus.limit = 4'd2; bus.mode = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("busy_len", nb, exp_busy);
    chk("done_cnt", nd, 1);
    chk("q_end", int'(bus.q), exp_q);
  endtask

  initial begin
    logic [3:0] ltv;
    logic [3:0] tv3;
    int         nd;
    bit         hit4;
    reset = 1'b1; bus.start = 1'b0; bus.mode = 1'b0; bus.limit = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_q", int'(bus.q), 0);
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_done", int'(bus.done), 0);
      chk("idle_t_vec", int'(bus.t_vec), 0);
    end

    run_op(4'd5, 1'b0, 1'b0, 8, 5, ltv, tv3);
    chk("up_t_vec_at_q3", int'(tv3), 7);
    run_op(4'hA, 1'b1, 1'b0, 13, 0, ltv, tv3);
    chk("down_load_t_vec", int'(ltv), 15);
    run_op(4'd0, 1'b0, 1'b0, 3, 0, ltv, tv3);
    run_op(4'd0, 1'b1, 1'b0, 3, 0, ltv, tv3);
    run_op(4'hF, 1'b0, 1'b0, 18, 15, ltv, tv3);
    run_op(4'd6, 1'b0, 1'b1, 9, 6, ltv, tv3);

    // Reset in the middle of an up count to 9.
    @(negedge clk);
    bus.start = 1'b1; bus.limit = 4'd9; bus.mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    nd = 0; hit4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) nd++;
      if (bus.busy && bus.q == 4'd4 && i > 0) begin
        hit4 = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_q4", int'(hit4), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_q", int'(bus.q), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_done", int'(bus.done) + nd, 0);
    run_op(4'd3, 1'b0, 1'b0, 6, 3, ltv, tv3);

    // Start held high: operations re-trigger after a single idle cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.limit = 4'd2; bus.mode = 1'b0;
    repeat (12) @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencing controller for a bank of T flip-flops. The bank is built from the team's single-bit T flip-flop (toggle on `t`, synchronous active-high `reset` clears `q`). On a start request the controller drives each flip-flop's toggle input: it first presets the bank in one cycle, then counts up or down one step per clock until a programmed terminal value is reached, then signals completion. It is the control layer that turns the raw T flip-flop datapath into a programmable up/down counter with a start/done handshake.

## Interface
- `N`, default 4: number of T flip-flops in the bank; width of `limit`, `t_vec`, `q`. Legal range 1–16.
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high; one clock, synchronous active-high reset as decided
- `start`  input  1  request; sampled only in IDLE
- `mode`  input  1  0 = count up 0→limit, 1 = count down limit→0; sampled with `start`
- `limit`  input  N  terminal (up) or initial (down) value; sampled with `start`
- `t_vec`  output  N  toggle vector applied to the bank this cycle (combinational from state, `q`, `mode_r`, `limit_r`)
- `q`  output  N  current bank contents (outputs of the N T flip-flops)
- `busy`  output  1  high in LOAD, RUN, DONE
- `done`  output  1  one-cycle pulse in DONE

## Operation
- Bank: N T flip-flops; bit i toggles at the clock edge when `t_vec[i]`=1; all bits clear on `reset`.
- Registers: `state`, `limit_r`, `mode_r`.
- States: IDLE, LOAD, RUN, DONE (2-bit encoding, free choice).
- IDLE: `t_vec`=0, `busy`=0, `done`=0. If `start`=1 at an edge, capture `limit_r`←`limit` and `mode_r`←`mode`, then go to LOAD.
- LOAD (1 cycle): `t_vec` = `q` XOR preset, where preset = 0 (up) or `limit_r` (down). After the edge, `q` = preset. Next state: RUN.
- RUN: end value = `limit_r` (up) or 0 (down).
  - If `q` == end: `t_vec`=0 and go to DONE.
  - Otherwise, up: `t_vec[0]`=1 and `t_vec[i]` = AND of `q[i-1:0]`.
  - Otherwise, down: `t_vec[0]`=1 and `t_vec[i]` = AND of ~`q[i-1:0]`.
  - Each RUN cycle therefore moves `q` by exactly ±1. There is no wrap-around, because the end value is always reached first.
- DONE (1 cycle): `t_vec`=0, `done`=1, `busy`=1. `q` holds the end value. Next state: IDLE.
- `q` is retained in IDLE until the next start or reset.
- `start` is ignored in LOAD, RUN and DONE; no queuing.
- `limit` and `mode` changes after capture have no effect.
- `limit`=0 in either mode: LOAD sets `q`=0, RUN immediately sees end, then DONE.

## Timing
- Reset values: `state`=IDLE, `q`=0, `t_vec`=0, `busy`=0, `done`=0, `limit_r`=0, `mode_r`=0.
- Reset has priority over everything. Reset asserted mid-operation returns to IDLE at that edge, clears `q`, and produces no `done` pulse.
- Edge E0 samples `start`. LOAD occupies the cycle after E0, RUN starts after E1 with `q` = preset.
- Let L = `limit_r`.
  - Up: RUN lasts L+1 cycles; `q`=L after E(1+L); DONE is the cycle after E(2+L).
  - Down: same count, with `q`=0 after E(1+L).
- `busy` is high for L+3 consecutive cycles. `done` is high in the last of them.
- Back-to-back operation: `start` held high re-triggers on the first IDLE edge, so IDLE lasts 1 cycle between operations.

## Test plan
- Reset then idle: `reset`=1 for 2 edges, `start`=0 → `q`=0, `busy`=0, `done`=0, `t_vec`=0 for 5 cycles.
- Up count, N=4, `limit`=5, `mode`=0, one-cycle `start`:
  - `q` after successive edges: 0,1,2,3,4,5, then held at 5.
  - `busy` high for 8 cycles; `done` high only in the 8th.
  - `t_vec` in RUN with `q`=3 is 4'b0111.
- Down count, `limit`=4'hA, `mode`=1, starting from `q`=5 left by the previous test:
  - LOAD `t_vec` = 5 XOR A = 4'hF.
  - `q` after successive edges: A,9,…,0.
  - `done` pulses once; `busy` high for 13 cycles.
- Boundaries:
  - `limit`=0 in both modes → `busy` high 3 cycles, `done` in the 3rd, `q`=0.
  - `limit`=4'hF in up mode → `q` reaches F and does not wrap to 0.
- Ignore `start` while busy: during an up count to 6, pulse `start` with `limit`=2 in RUN → the run still ends at `q`=6 and `done` pulses once.
- Reset mid-RUN: in an up count to 9, assert `reset` when `q`=4 → `q`=0, IDLE, `busy`=0 on the next cycle, no `done` pulse; a subsequent start works normally.
